// File: rtl/writeback_stage.sv
// writeback_stage
//   Final (W) stage of the 5-stage pipeline. Latches one instruction from the
//   memory stage and commits it in the following cycle: a register-file write,
//   a CSR write, or an exception raise (ex_en flush pulse). Also drives the WD
//   forwarding bus, the branch-predictor update bus, and a small debug-trace
//   FIFO whose fullness back-pressures the pipeline.
//
// Ports
//   clk, rstn            clock; synchronous active-low reset
//   MW_valid, MW_BUS     incoming instruction from the memory stage
//   W_allowin            W stage can accept an instruction this cycle
//   rf_we/waddr/wdata    register-file write port
//   csr_we/addr/wmask/wdata  CSR write port (address/mask/data always driven)
//   ex_en, ex_ecode, ex_esubcode, ex_pc, ex_vaddr  exception commit
//   pb_valid, pb_bus     branch-predictor update
//   WD_for_BUS           {forwardable dest, result} for hazard forwarding
//   trace_valid/ready    trace FIFO head handshake
//   trace_pc/we/wnum/wdata  trace FIFO head fields (zero when empty)
module writeback_stage #(
    parameter int MW_WID      = 258,
    parameter int PB_WID      = 67,
    parameter int TRACE_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              MW_valid,
    input  logic [MW_WID-1:0] MW_BUS,
    output logic              W_allowin,
    output logic              rf_we,
    output logic [4:0]        rf_waddr,
    output logic [31:0]       rf_wdata,
    output logic              csr_we,
    output logic [13:0]       csr_addr,
    output logic [31:0]       csr_wmask,
    output logic [31:0]       csr_wdata,
    output logic              ex_en,
    output logic [7:0]        ex_ecode,
    output logic              ex_esubcode,
    output logic [31:0]       ex_pc,
    output logic [31:0]       ex_vaddr,
    output logic              pb_valid,
    output logic [PB_WID-1:0] pb_bus,
    output logic [36:0]       WD_for_BUS,
    output logic              trace_valid,
    input  logic              trace_ready,
    output logic [31:0]       trace_pc,
    output logic [3:0]        trace_we,
    output logic [4:0]        trace_wnum,
    output logic [31:0]       trace_wdata
);

    localparam int PTR_W = (TRACE_DEPTH > 1) ? $clog2(TRACE_DEPTH) : 1;
    localparam int CNT_W = $clog2(TRACE_DEPTH) + 1;
    localparam int ENT_W = 32 + 4 + 5 + 32;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(TRACE_DEPTH);

    logic              w_valid;
    logic [MW_WID-1:0] mw_r;

    // Decoded fields of the held instruction
    logic [31:0] f_pc;
    logic [31:0] f_result;
    logic        f_gr_we;
    logic [4:0]  f_dest;
    logic [31:0] f_vaddr;
    logic        f_ex;
    logic [7:0]  f_ecode;
    logic        f_esub;
    logic [13:0] f_csr_addr;
    logic        f_csr_we;
    logic [31:0] f_csr_wmask;
    logic [31:0] f_csr_wdata;

    assign pb_bus      = mw_r[MW_WID-1 -: PB_WID];
    assign f_pc        = mw_r[190:159];
    assign f_result    = mw_r[158:127];
    assign f_gr_we     = mw_r[126];
    assign f_dest      = mw_r[125:121];
    assign f_vaddr     = mw_r[120:89];
    assign f_ex        = mw_r[88];
    assign f_ecode     = mw_r[87:80];
    assign f_esub      = mw_r[79];
    assign f_csr_addr  = mw_r[78:65];
    assign f_csr_we    = mw_r[64];
    assign f_csr_wmask = mw_r[63:32];
    assign f_csr_wdata = mw_r[31:0];

    logic [CNT_W-1:0] trace_count;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [ENT_W-1:0] trace_mem [TRACE_DEPTH];
    logic [ENT_W-1:0] head;

    logic w_ready_go;
    logic commit;
    logic push;
    logic pop;

    // A pop in the same cycle does not free a slot for this cycle's commit,
    // so a full FIFO always costs one stall cycle.
    assign w_ready_go = (trace_count < DEPTH_C);
    assign W_allowin  = !w_valid || w_ready_go;
    assign commit     = w_valid && w_ready_go;

    assign ex_en       = commit && f_ex;
    assign ex_ecode    = f_ecode;
    assign ex_esubcode = f_esub;
    assign ex_pc       = f_pc;
    assign ex_vaddr    = f_vaddr;

    assign rf_we    = commit && f_gr_we && !f_ex && (f_dest != 5'd0);
    assign rf_waddr = f_dest;
    assign rf_wdata = f_result;

    assign csr_we    = commit && f_csr_we && !f_ex;
    assign csr_addr  = f_csr_addr;
    assign csr_wmask = f_csr_wmask;
    assign csr_wdata = f_csr_wdata;

    assign pb_valid = commit && !f_ex;

    assign WD_for_BUS = {f_dest & {5{w_valid && f_gr_we && !f_ex}}, f_result};

    always_ff @(posedge clk) begin
        if (!rstn) begin
            w_valid <= 1'b0;
            mw_r    <= '0;
        end else if (MW_valid && W_allowin && !ex_en) begin
            w_valid <= 1'b1;
            mw_r    <= MW_BUS;
        end else if (W_allowin) begin
            w_valid <= 1'b0;
        end
    end

    assign push        = commit && !f_ex;
    assign trace_valid = (trace_count != '0);
    assign pop         = trace_valid && trace_ready;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            trace_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   trace_count <= trace_count + 1'b1;
                2'b01:   trace_count <= trace_count - 1'b1;
                default: trace_count <= trace_count;
            endcase
        end
    end

    // Storage needs no reset: the head is masked to zero whenever empty.
    always_ff @(posedge clk) begin
        if (push) trace_mem[wr_ptr] <= {f_pc, {4{rf_we}}, f_dest, f_result};
    end

    assign head = trace_valid ? trace_mem[rd_ptr] : '0;
    assign trace_pc    = head[72:41];
    assign trace_we    = head[40:37];
    assign trace_wnum  = head[36:32];
    assign trace_wdata = head[31:0];

endmodule

// File: tb/tb_writeback_stage.sv
module tb_writeback_stage;

    localparam int DEPTH = 2;

    typedef struct packed {
        logic [66:0] pb;
        logic [31:0] pc;
        logic [31:0] result;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] vaddr;
        logic        ex;
        logic [7:0]  ecode;
        logic        esub;
        logic [13:0] csr_addr;
        logic        csr_we;
        logic [31:0] csr_wmask;
        logic [31:0] csr_wdata;
    } ins_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [3:0]  we;
        logic [4:0]  wnum;
        logic [31:0] wdata;
    } trace_t;

    logic         clk;
    logic         rstn;
    logic         mw_valid;
    logic [257:0] mw_bus;
    logic         W_allowin;
    logic         rf_we;
    logic [4:0]   rf_waddr;
    logic [31:0]  rf_wdata;
    logic         csr_we;
    logic [13:0]  csr_addr;
    logic [31:0]  csr_wmask;
    logic [31:0]  csr_wdata;
    logic         ex_en;
    logic [7:0]   ex_ecode;
    logic         ex_esubcode;
    logic [31:0]  ex_pc;
    logic [31:0]  ex_vaddr;
    logic         pb_valid;
    logic [66:0]  pb_bus;
    logic [36:0]  WD_for_BUS;
    logic         trace_valid;
    logic         trace_ready;
    logic [31:0]  trace_pc;
    logic [3:0]   trace_we;
    logic [4:0]   trace_wnum;
    logic [31:0]  trace_wdata;

    writeback_stage #(.MW_WID(258), .PB_WID(67), .TRACE_DEPTH(DEPTH)) dut (
        .clk(clk), .rstn(rstn), .MW_valid(mw_valid), .MW_BUS(mw_bus),
        .W_allowin(W_allowin),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .csr_we(csr_we), .csr_addr(csr_addr), .csr_wmask(csr_wmask), .csr_wdata(csr_wdata),
        .ex_en(ex_en), .ex_ecode(ex_ecode), .ex_esubcode(ex_esubcode),
        .ex_pc(ex_pc), .ex_vaddr(ex_vaddr),
        .pb_valid(pb_valid), .pb_bus(pb_bus), .WD_for_BUS(WD_for_BUS),
        .trace_valid(trace_valid), .trace_ready(trace_ready),
        .trace_pc(trace_pc), .trace_we(trace_we), .trace_wnum(trace_wnum),
        .trace_wdata(trace_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   total = 0;
    int   bad   = 0;

    // Reference model: the instruction held in W, the last captured payload,
    // and the trace FIFO contents as a queue.
    bit     w_has;
    ins_t   r;
    trace_t tq[$];
    ins_t   cur_ins;
    bit     accepted;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input ins_t i);
        cur_ins = i;
        mw_bus  = i;
    endtask

    function automatic ins_t blank();
        ins_t i;
        i = '0;
        return i;
    endfunction

    function automatic ins_t rand_ins();
        ins_t i;
        i           = '0;
        i.pb        = 67'({$urandom(), $urandom(), $urandom()});
        i.pc        = $urandom();
        i.result    = $urandom();
        i.gr_we     = 1'($urandom());
        i.dest      = (($urandom() % 6) == 0) ? 5'd0 : 5'($urandom());
        i.vaddr     = $urandom();
        i.ex        = (($urandom() % 8) == 0);
        i.ecode     = 8'($urandom());
        i.esub      = 1'($urandom());
        i.csr_addr  = 14'($urandom());
        i.csr_we    = 1'($urandom());
        i.csr_wmask = $urandom();
        i.csr_wdata = $urandom();
        return i;
    endfunction

    task automatic check_all();
        bit     rg, allow, com, e_ex, e_rf, e_csr, e_pb, fwd;
        trace_t h;
        rg    = (tq.size() < DEPTH);
        allow = !w_has || rg;
        com   = w_has && rg;
        e_ex  = com && r.ex;
        e_rf  = com && r.gr_we && !r.ex && (r.dest != 5'd0);
        e_csr = com && r.csr_we && !r.ex;
        e_pb  = com && !r.ex;
        fwd   = w_has && r.gr_we && !r.ex;
        h     = (tq.size() > 0) ? tq[0] : '0;
        chk("W_allowin",   128'(W_allowin),   128'(allow));
        chk("rf_we",       128'(rf_we),       128'(e_rf));
        chk("rf_waddr",    128'(rf_waddr),    128'(r.dest));
        chk("rf_wdata",    128'(rf_wdata),    128'(r.result));
        chk("csr_we",      128'(csr_we),      128'(e_csr));
        chk("csr_addr",    128'(csr_addr),    128'(r.csr_addr));
        chk("csr_wmask",   128'(csr_wmask),   128'(r.csr_wmask));
        chk("csr_wdata",   128'(csr_wdata),   128'(r.csr_wdata));
        chk("ex_en",       128'(ex_en),       128'(e_ex));
        chk("ex_ecode",    128'(ex_ecode),    128'(r.ecode));
        chk("ex_esubcode", 128'(ex_esubcode), 128'(r.esub));
        chk("ex_pc",       128'(ex_pc),       128'(r.pc));
        chk("ex_vaddr",    128'(ex_vaddr),    128'(r.vaddr));
        chk("pb_valid",    128'(pb_valid),    128'(e_pb));
        chk("pb_bus",      128'(pb_bus),      128'(r.pb));
        chk("WD_for_BUS",  128'(WD_for_BUS),  128'({r.dest & {5{fwd}}, r.result}));
        chk("trace_valid", 128'(trace_valid), 128'(tq.size() > 0));
        chk("trace_pc",    128'(trace_pc),    128'(h.pc));
        chk("trace_we",    128'(trace_we),    128'(h.we));
        chk("trace_wnum",  128'(trace_wnum),  128'(h.wnum));
        chk("trace_wdata", 128'(trace_wdata), 128'(h.wdata));
    endtask

    task automatic model_update();
        bit rg, allow, com, e_ex, e_rf;
        rg    = (tq.size() < DEPTH);
        allow = !w_has || rg;
        com   = w_has && rg;
        e_ex  = com && r.ex;
        e_rf  = com && r.gr_we && !r.ex && (r.dest != 5'd0);
        accepted = 1'b0;
        if (!rstn) begin
            w_has = 1'b0;
            r     = '0;
            tq.delete();
        end else begin
            if (tq.size() > 0 && trace_ready) void'(tq.pop_front());
            if (com && !r.ex) tq.push_back({r.pc, {4{e_rf}}, r.dest, r.result});
            if (mw_valid && allow && !e_ex) begin
                w_has    = 1'b1;
                r        = cur_ins;
                accepted = 1'b1;
            end else if (allow) begin
                w_has = 1'b0;
            end
        end
    endtask

    // Called at a negedge with inputs set; checks, crosses one posedge, returns at next negedge.
    task automatic step();
        #1;
        check_all();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic offer(input ins_t i);
        int n;
        drive(i);
        mw_valid = 1'b1;
        n = 0;
        do begin
            step();
            n++;
        end while (!accepted && n < 20);
        chk("offer_accepted", 128'(accepted), 128'(1));
    endtask

    task automatic fill_three(input logic [31:0] base);
        ins_t a;
        for (int k = 1; k <= 3; k++) begin
            a        = blank();
            a.pc     = base + 32'(4 * k);
            a.gr_we  = 1'b1;
            a.dest   = 5'(k);
            a.result = 32'h1000 + 32'(k);
            offer(a);
        end
        mw_valid = 1'b0;
    endtask

    initial begin
        ins_t i;
        rstn        = 1'b0;
        mw_valid    = 1'b0;
        mw_bus      = '0;
        cur_ins     = '0;
        trace_ready = 1'b0;
        w_has       = 1'b0;
        r           = '0;
        @(posedge clk);
        @(negedge clk);
        step();
        step();
        rstn = 1'b1;
        step();

        // Single ALU op
        trace_ready = 1'b1;
        i = blank(); i.pc = 32'h1C00_0000; i.dest = 5'd5; i.result = 32'hDEAD_BEEF; i.gr_we = 1'b1;
        offer(i);
        mw_valid = 1'b0;
        #1;
        chk("t1_rf_we",    128'(rf_we),    128'(1));
        chk("t1_rf_waddr", 128'(rf_waddr), 128'(5));
        chk("t1_rf_wdata", 128'(rf_wdata), 128'(32'hDEAD_BEEF));
        step();
        #1;
        chk("t1_trace_we", 128'(trace_we), 128'(4'hF));
        chk("t1_trace_pc", 128'(trace_pc), 128'(32'h1C00_0000));
        step();

        // Write to r0 is dropped and not forwarded
        i = blank(); i.pc = 32'h1C00_0004; i.dest = 5'd0; i.result = 32'h1234_5678; i.gr_we = 1'b1;
        offer(i);
        mw_valid = 1'b0;
        #1;
        chk("t2_rf_we", 128'(rf_we), 128'(0));
        chk("t2_fwd",   128'(WD_for_BUS[36:32]), 128'(0));
        step();
        #1;
        chk("t2_trace_we", 128'(trace_we), 128'(0));
        step();

        // Exception: flush pulse, no writes, next offer refused that cycle
        i = blank(); i.ex = 1'b1; i.ecode = 8'h0B; i.pc = 32'h1C00_0010; i.csr_we = 1'b1; i.gr_we = 1'b1; i.dest = 5'd7;
        offer(i);
        i = blank(); i.pc = 32'h1C00_0014; i.gr_we = 1'b1; i.dest = 5'd9; i.result = 32'h55;
        drive(i);
        #1;
        chk("t3_ex_en",   128'(ex_en),   128'(1));
        chk("t3_ex_pc",   128'(ex_pc),   128'(32'h1C00_0010));
        chk("t3_ecode",   128'(ex_ecode), 128'(8'h0B));
        chk("t3_csr_we",  128'(csr_we),  128'(0));
        chk("t3_rf_we",   128'(rf_we),   128'(0));
        step();
        chk("t3_refused", 128'(accepted), 128'(0));
        #1;
        chk("t3_ex_pulse", 128'(ex_en), 128'(0));
        offer(i);
        mw_valid = 1'b0;
        step();
        step();

        // Trace back-pressure and drain
        trace_ready = 1'b0;
        fill_three(32'h1C00_0100);
        #1;
        chk("t4_stall", 128'(W_allowin), 128'(0));
        step();
        step();
        trace_ready = 1'b1;
        #1;
        chk("t4_pop_cycle_rf_we", 128'(rf_we), 128'(0));
        step();
        #1;
        chk("t4_third_commit", 128'(rf_we), 128'(1));
        chk("t4_third_dest",   128'(rf_waddr), 128'(3));
        step();
        step();
        step();
        step();

        // CSR write
        i = blank(); i.csr_we = 1'b1; i.csr_addr = 14'h006; i.csr_wmask = 32'hFFFF_FFFF; i.csr_wdata = 32'h1;
        offer(i);
        mw_valid = 1'b0;
        #1;
        chk("t5_csr_we",    128'(csr_we),    128'(1));
        chk("t5_csr_addr",  128'(csr_addr),  128'(14'h006));
        chk("t5_csr_wmask", 128'(csr_wmask), 128'(32'hFFFF_FFFF));
        chk("t5_csr_wdata", 128'(csr_wdata), 128'(32'h1));
        step();
        #1;
        chk("t5_csr_pulse", 128'(csr_we), 128'(0));
        step();

        // Reset while stalled with a full trace FIFO
        trace_ready = 1'b0;
        fill_three(32'h1C00_0200);
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        #1;
        chk("t6_trace_valid", 128'(trace_valid), 128'(0));
        chk("t6_allowin",     128'(W_allowin),   128'(1));
        chk("t6_rf_we",       128'(rf_we),       128'(0));
        step();
        step();

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            drive(rand_ins());
            mw_valid    = (($urandom() % 4) != 0);
            trace_ready = (($urandom() % 3) != 0);
            rstn        = (($urandom() % 100) != 0);
            step();
        end
        rstn = 1'b1;
        mw_valid = 1'b0;
        trace_ready = 1'b1;
        for (int n = 0; n < 6; n++) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
